// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD core front end.
// Fetch FSM encoding, NOP word and opcode field layout.
package simd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_HALT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'd0;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 3;

    localparam logic [3:0] OP_LOAD   = 4'd2;
    localparam logic [3:0] OP_LOAD_B = 4'd3;
    localparam logic [3:0] OP_MAC    = 4'd4;
    localparam logic [3:0] OP_STORE  = 4'd5;
    localparam logic [3:0] OP_END    = 4'd6;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register plus fetch FSM feeding the control unit.
// One instruction is presented at a time; NOP is shown between instructions.
module instr_fetch
    import simd_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START_SIGNAL,
    input  logic              PC_INCR,
    input  logic              INSTR_DONE,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic              IMEM_RDEN,
    input  logic [31:0]       IMEM_RDATA,
    output logic [31:0]       INSTR,
    output logic              INSTR_VALID,
    output logic              HALTED,
    output logic              PC_OVF
);

    localparam logic [ADDR_W-1:0] PC_MAX = '1;

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [31:0]       instr_nxt;
    logic              valid_nxt;
    logic              halted_nxt;
    logic              ovf_nxt;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            INSTR       <= NOP_INSTR;
            INSTR_VALID <= 1'b0;
            HALTED      <= 1'b0;
            PC_OVF      <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            INSTR       <= instr_nxt;
            INSTR_VALID <= valid_nxt;
            HALTED      <= halted_nxt;
            PC_OVF      <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_nxt  = INSTR;
        valid_nxt  = INSTR_VALID;
        halted_nxt = HALTED;
        ovf_nxt    = PC_OVF;
        unique case (state)
            S_IDLE: begin
                if (START_SIGNAL) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                instr_nxt = IMEM_RDATA;
                valid_nxt = 1'b1;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                // INSTR_DONE has priority over PC_INCR in the same cycle
                if (INSTR_DONE) begin
                    instr_nxt  = NOP_INSTR;
                    valid_nxt  = 1'b0;
                    halted_nxt = 1'b1;
                    state_nxt  = S_HALT;
                end else if (PC_INCR) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                    if (pc == PC_MAX) begin
                        ovf_nxt    = 1'b1;
                        halted_nxt = 1'b1;
                        state_nxt  = S_HALT;
                    end else begin
                        pc_nxt    = pc + 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                if (!START_SIGNAL) begin
                    pc_nxt     = RESET_PC;
                    halted_nxt = 1'b0;
                    ovf_nxt    = 1'b0;
                    state_nxt  = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign IMEM_ADDR = pc;
    assign IMEM_RDEN = (state == S_FETCH);

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed bench for instr_fetch against a countdown-based
// behavioural model of the fetch protocol.
module tb_instr_fetch;

    localparam int AW = 8;
    localparam int DEPTH = 1 << AW;
    localparam int MI = 0;
    localparam int MR = 1;
    localparam int MH = 2;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          START_SIGNAL;
    logic          PC_INCR;
    logic          INSTR_DONE;
    logic [AW-1:0] IMEM_ADDR;
    logic          IMEM_RDEN;
    logic [31:0]   IMEM_RDATA;
    logic [31:0]   INSTR;
    logic          INSTR_VALID;
    logic          HALTED;
    logic          PC_OVF;

    logic [31:0] mem [DEPTH];

    int checks = 0;
    int failures = 0;

    int          m_mode;
    int          m_cnt;
    int          m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_halt;
    logic        m_ovf;

    instr_fetch #(.ADDR_W(AW), .RESET_PC('0)) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .START_SIGNAL(START_SIGNAL),
        .PC_INCR     (PC_INCR),
        .INSTR_DONE  (INSTR_DONE),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_RDEN   (IMEM_RDEN),
        .IMEM_RDATA  (IMEM_RDATA),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .HALTED      (HALTED),
        .PC_OVF      (PC_OVF)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (IMEM_RDEN) IMEM_RDATA <= mem[IMEM_ADDR];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = MI;
        m_cnt   = 0;
        m_pc    = 0;
        m_instr = 32'd0;
        m_valid = 1'b0;
        m_halt  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Run = countdown of 2 cycles to a valid word, then hold until a pulse.
    task automatic model_edge(input logic s, input logic i, input logic d);
        if (m_mode == MI) begin
            if (s) begin
                m_mode = MR;
                m_cnt  = 2;
            end
        end else if (m_mode == MR) begin
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_instr = mem[m_pc];
                    m_valid = 1'b1;
                end
            end else if (d) begin
                m_instr = 32'd0;
                m_valid = 1'b0;
                m_halt  = 1'b1;
                m_mode  = MH;
            end else if (i) begin
                m_instr = 32'd0;
                m_valid = 1'b0;
                if (m_pc == DEPTH - 1) begin
                    m_ovf  = 1'b1;
                    m_halt = 1'b1;
                    m_mode = MH;
                end else begin
                    m_pc++;
                    m_cnt = 2;
                end
            end
        end else begin
            if (!s) model_reset();
        end
    endtask

    task automatic compare();
        chk("instr", INSTR, m_instr);
        chk("valid", {31'd0, INSTR_VALID}, {31'd0, m_valid});
        chk("halted", {31'd0, HALTED}, {31'd0, m_halt});
        chk("pc_ovf", {31'd0, PC_OVF}, {31'd0, m_ovf});
        chk("rden", {31'd0, IMEM_RDEN},
            {31'd0, (m_mode == MR && m_cnt == 2)});
        chk("addr", {24'd0, IMEM_ADDR}, m_pc[31:0]);
    endtask

    task automatic step(input logic s, input logic i, input logic d);
        START_SIGNAL = s;
        PC_INCR      = i;
        INSTR_DONE   = d;
        @(posedge CLK);
        model_edge(s, i, d);
        #1;
        compare();
    endtask

    task automatic idle(input int n, input logic s);
        for (int k = 0; k < n; k++) step(s, 1'b0, 1'b0);
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
        mem[0] = 32'h1522;
        mem[1] = 32'h1983;
        mem[2] = 32'h4;
        mem[3] = 32'h605;
        IMEM_RDATA   = 32'd0;
        START_SIGNAL = 1'b0;
        PC_INCR      = 1'b0;
        INSTR_DONE   = 1'b0;
        RSTN         = 1'b0;
        model_reset();
        #3;
        compare();
        @(posedge CLK);
        #1 RSTN = 1'b1;

        // first fetch and a long hold without PC_INCR
        idle(2, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(12, 1'b1);
        chk("first_instr", INSTR, 32'h1522);

        // two advances, then simultaneous pulses at PC=2
        for (int n = 0; n < 2; n++) begin
            step(1'b1, 1'b1, 1'b0);
            idle(4, 1'b1);
        end
        step(1'b1, 1'b1, 1'b1);
        idle(5, 1'b1);
        chk("halt_pc", {24'd0, IMEM_ADDR}, 32'd2);

        // release start, re-arm, then walk addresses 1..3
        idle(2, 1'b0);
        chk("rearm_pc", {24'd0, IMEM_ADDR}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b1, 1'b0);
            idle(4, 1'b0);
        end
        chk("third_instr", INSTR, 32'h605);
        step(1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);

        // reset in the WAIT state
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        #2 RSTN = 1'b0;
        #1;
        model_reset();
        compare();
        #2 RSTN = 1'b1;
        idle(4, 1'b0);

        // randomized run
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 8) != 0, ($urandom % 3) == 0,
                 ($urandom % 40) == 0);
        end

        // overflow at the last address
        idle(3, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < DEPTH; n++) begin
            idle(2, 1'b1);
            step(1'b1, 1'b1, 1'b0);
        end
        idle(5, 1'b1);
        chk("ovf_flag", {31'd0, PC_OVF}, 32'd1);
        idle(2, 1'b0);
        chk("ovf_clear", {31'd0, PC_OVF}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the control unit. Holds the program counter, reads 32-bit instructions from a synchronous instruction memory, and presents one instruction at a time on `INSTR`. It advances only when the control unit pulses `PC_INCR`, and halts when the control unit asserts `INSTR_DONE`. A run is armed by the GPIO `START_SIGNAL`.

## Interface
- `ADDR_W`, 8, PC / instruction memory address width
- `RESET_PC`, 0, PC value after reset and at the start of each run
- `CLK`  in  1  system clock, rising edge
- `RSTN`  in  1  asynchronous active-low reset
- `START_SIGNAL`  in  1  GPIO run request, level
- `PC_INCR`  in  1  control unit: current instruction consumed, fetch next (1-cycle pulse)
- `INSTR_DONE`  in  1  control unit: program finished (1-cycle pulse)
- `IMEM_ADDR`  out  ADDR_W  instruction memory read address (= PC)
- `IMEM_RDEN`  out  1  instruction memory read enable
- `IMEM_RDATA`  in  32  read data, valid exactly one cycle after `IMEM_RDEN`
- `INSTR`  out  32  instruction to control unit; 32'd0 (NOP) whenever not valid
- `INSTR_VALID`  out  1  `INSTR` holds a fetched instruction
- `HALTED`  out  1  run finished, waiting for `START_SIGNAL` release
- `PC_OVF`  out  1  sticky: `PC_INCR` received at the last address

## Operation
- States: IDLE, FETCH, WAIT, HOLD, HALT.
- IDLE: `INSTR`=0, `INSTR_VALID`=0. `START_SIGNAL`=1 → FETCH.
- FETCH (1 cycle): `IMEM_RDEN`=1, `IMEM_ADDR`=PC → WAIT.
- WAIT (1 cycle): capture `IMEM_RDATA` into `INSTR`, set `INSTR_VALID` → HOLD.
- HOLD: `INSTR` is stable and `INSTR_VALID`=1.
  - `PC_INCR`: PC←PC+1, `INSTR`←0, `INSTR_VALID`←0 → FETCH.
  - `INSTR_DONE`: `INSTR`←0, `INSTR_VALID`←0, `HALTED`←1 → HALT.
  - Both pulses in the same cycle: `INSTR_DONE` wins. PC is unchanged.
- HALT: `START_SIGNAL`=0 → IDLE with PC←`RESET_PC`, `HALTED`←0, `PC_OVF`←0. While `START_SIGNAL` stays 1, remain in HALT (no automatic re-run).
- `PC_INCR` at PC = 2^ADDR_W−1: no wrap. `PC_OVF`←1, `HALTED`←1 → HALT.
- `PC_INCR` or `INSTR_DONE` outside HOLD: ignored.
- `START_SIGNAL` dropping during FETCH, WAIT or HOLD: ignored, the run continues.
- PC arithmetic is unsigned ADDR_W-bit. `IMEM_ADDR` is driven from PC combinationally. `IMEM_RDEN` is decoded from state.

## Timing
- Reset values: state IDLE, PC=`RESET_PC`, `INSTR`=0, `INSTR_VALID`=0, `IMEM_RDEN`=0, `HALTED`=0, `PC_OVF`=0.
- `RSTN` low at any time, including mid-fetch, clears everything immediately. Read data in flight is discarded.
- `START_SIGNAL` sampled high at edge t: `IMEM_RDEN` high in cycle t..t+1, data captured at edge t+2, `INSTR_VALID` high from edge t+2.
- `PC_INCR` sampled at edge t: `INSTR`=0 from t, next instruction valid from edge t+2.
- Throughput: at most one instruction per 3 cycles. The control unit sees NOP between instructions.
- `INSTR` changes only at the entry to and exit from HOLD.

## Structure
- Shared package `simd_pkg` contains:
  - `fetch_state_t` enum.
  - `NOP_INSTR` = 32'd0.
  - Opcode field position `[3:0]`.
  - Opcode localparams: LOAD=4'd2, LOAD_B=4'd3, MAC=4'd4, STORE=4'd5, END=4'd6.
- No sub-module: single FSM plus PC register. Target is about 150 lines of RTL.

## Test plan
- Reset, then `START_SIGNAL`=1 with IMEM[0]=32'h1522 → `IMEM_RDEN` pulses with addr 0; `INSTR`=32'h1522 and `INSTR_VALID`=1 two edges after start, held stable for 10 cycles without `PC_INCR`.
- Three `PC_INCR` pulses spaced 5 cycles apart with IMEM[1..3]=32'h1983, 32'h4, 32'h605 → addresses 1, 2, 3 fetched in order; `INSTR`=0 for 2 cycles between instructions.
- `PC_INCR` and `INSTR_DONE` in the same cycle at PC=2 → HALT, `HALTED`=1, PC stays 2, `INSTR`=0; holding `START_SIGNAL`=1 for 5 cycles causes no fetch.
- From HALT, drop `START_SIGNAL`, then re-raise it → IDLE with PC=0, then a fetch from address 0 again.
- With `ADDR_W`=2, issue `PC_INCR` at PC=3 → `PC_OVF`=1, `HALTED`=1, no fetch of address 0.
- Assert `RSTN`=0 in the WAIT state → all outputs 0 immediately; after release, `INSTR` stays 0 until `START_SIGNAL` is seen again.
